// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-port SDRAM request arbiter:
// FSM state encoding, port indices and bus widths.
package sdram_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_ISSUE = 2'd1,
        STATE_DONE  = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/sdram_arbiter_select.sv
// Combinational priority picker: chooses which of two requesters wins.
// With ROUND_ROBIN != 0 a tie goes to the port not granted last,
// otherwise a tie always goes to the CPU port.
module sdram_arbiter_select
    import sdram_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_port
);

    // Pick the winning port from the current request vector and last grant
    always_comb begin
        gnt_vld  = |req;
        gnt_port = PORT_CPU;
        if (req == 2'b10) begin
            gnt_port = PORT_DMA;
        end else if ((req == 2'b11) && (ROUND_ROBIN != 0) && (last == PORT_CPU)) begin
            gnt_port = PORT_DMA;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller. Grants one requester
// at a time, latches its command into the controller request interface,
// and returns read data plus a one-cycle ack to the winning port.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              busy_q, busy_d;
    logic              gnt_vld;
    logic              gnt_port;

    sdram_arbiter_select #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_select (
        .req      ({p1_req, p0_req}),
        .last     (last_q),
        .gnt_vld  (gnt_vld),
        .gnt_port (gnt_port)
    );

    // State and output registers; reset aborts any access with no ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= STATE_IDLE;
            port_q      <= PORT_CPU;
            last_q      <= PORT_DMA;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: requests are only sampled in IDLE; mem_ack only counts in ISSUE
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE:  if (gnt_vld) state_d = STATE_ISSUE;
            STATE_ISSUE: if (mem_ack) state_d = STATE_DONE;
            STATE_DONE:  state_d = STATE_IDLE;
            default:     state_d = STATE_IDLE;
        endcase
    end

    // Register updates: latch the winner on grant, complete on controller ack
    always_comb begin
        port_d      = port_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        busy_d      = (state_d != STATE_IDLE);
        case (state_q)
            STATE_IDLE: begin
                if (gnt_vld) begin
                    port_d      = gnt_port;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = (gnt_port == PORT_DMA) ? p1_wr    : p0_wr;
                    mem_addr_d  = (gnt_port == PORT_DMA) ? p1_addr  : p0_addr;
                    mem_wdata_d = (gnt_port == PORT_DMA) ? p1_wdata : p0_wdata;
                end
            end
            STATE_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    last_d    = port_q;
                    if (port_q == PORT_DMA) begin
                        p1_ack_d = 1'b1;
                        if (!mem_wr_q) p1_rdata_d = mem_rdata;
                    end else begin
                        p0_ack_d = 1'b1;
                        if (!mem_wr_q) p0_rdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: one round-robin and one fixed-priority
// instance share the same requesters and a simple controller model.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_wr, p1_req, p1_wr;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [15:0] mem_rdata;
    logic        model_ack, spur_ack;
    logic        mem_ack;
    logic [1:0]  model_cnt;

    logic [15:0] r_p0_rdata, r_p1_rdata, r_mem_addr, r_mem_wdata;
    logic        r_p0_ack, r_p1_ack, r_mem_req, r_mem_wr, r_busy;
    logic [15:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;
    logic        f_p0_ack, f_p1_ack, f_mem_req, f_mem_wr, f_busy;

    int n_cmp = 0;
    int n_err = 0;

    assign mem_ack = model_ack | spur_ack;

    always #5 clk = ~clk;

    sdram_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(r_p0_rdata), .p0_ack(r_p0_ack),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(r_p1_rdata), .p1_ack(r_p1_ack),
        .mem_req(r_mem_req), .mem_wr(r_mem_wr), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(r_busy)
    );

    sdram_arbiter #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(f_p0_rdata), .p0_ack(f_p0_ack),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(f_p1_rdata), .p1_ack(f_p1_ack),
        .mem_req(f_mem_req), .mem_wr(f_mem_wr), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(f_busy)
    );

    // Controller model: acks the third cycle that mem_req has been high
    always @(posedge clk) begin
        if (!rst) begin
            model_cnt <= 2'd0;
            model_ack <= 1'b0;
        end else begin
            model_ack <= 1'b0;
            if (r_mem_req && !model_ack) begin
                if (model_cnt == 2'd2) begin
                    model_ack <= 1'b1;
                    model_cnt <= 2'd0;
                end else begin
                    model_cnt <= model_cnt + 2'd1;
                end
            end else begin
                model_cnt <= 2'd0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit port, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if ((port ? r_p1_ack : r_p0_ack) == 1'b1) seen = 1'b1;
            else tick();
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
    endtask

    logic [15:0] rr_exp [5];
    logic [15:0] fp_exp [5];

    initial begin
        int g, gap, acks;
        logic prev;
        rr_exp = '{16'h0A00, 16'h0B00, 16'h0A00, 16'h0B00, 16'h0B00};
        fp_exp = '{16'h0A00, 16'h0A00, 16'h0A00, 16'h0A00, 16'h0B00};
        rst = 1'b0; spur_ack = 1'b0; mem_rdata = 16'h0;
        p0_req = 0; p0_wr = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_wr = 0; p1_addr = 0; p1_wdata = 0;

        // Reset state
        tick(); tick();
        chk("rst_mem_req", r_mem_req, 0);
        chk("rst_busy", r_busy, 0);
        chk("rst_mem_addr", r_mem_addr, 16'h0);
        chk("rst_p0_rdata", r_p0_rdata, 16'h0);
        chk("rst_acks", {r_p0_ack, r_p1_ack}, 2'b00);
        rst = 1'b1;
        tick();

        // Single read from p0
        p0_req = 1; p0_wr = 0; p0_addr = 16'h00A5; mem_rdata = 16'hBEEF;
        tick();
        chk("rd_mem_req", r_mem_req, 1);
        chk("rd_mem_addr", r_mem_addr, 16'h00A5);
        chk("rd_mem_wr", r_mem_wr, 0);
        chk("rd_busy", r_busy, 1);
        wait_ack(1'b0, "rd_ack_timeout");
        chk("rd_p0_rdata", r_p0_rdata, 16'hBEEF);
        chk("rd_p1_ack", r_p1_ack, 0);
        chk("rd_mem_req_drop", r_mem_req, 0);
        p0_req = 0;
        tick();
        chk("rd_ack_one_cycle", r_p0_ack, 0);
        chk("rd_idle", r_busy, 0);
        chk("rd_rdata_hold", r_p0_rdata, 16'hBEEF);

        // p1 write, fields changed after grant
        p1_req = 1; p1_wr = 1; p1_addr = 16'h0100; p1_wdata = 16'h5555; mem_rdata = 16'h1111;
        tick();
        p1_wdata = 16'hAAAA; p1_addr = 16'hFFFF;
        chk("wr_mem_wr", r_mem_wr, 1);
        chk("wr_mem_addr", r_mem_addr, 16'h0100);
        chk("wr_mem_wdata", r_mem_wdata, 16'h5555);
        tick();
        chk("wr_mem_wdata_held", r_mem_wdata, 16'h5555);
        chk("wr_mem_addr_held", r_mem_addr, 16'h0100);
        wait_ack(1'b1, "wr_ack_timeout");
        chk("wr_p1_rdata_kept", r_p1_rdata, 16'h0000);
        p1_req = 0;
        tick();

        // Both ports requesting: round-robin vs fixed priority
        p0_req = 1; p0_wr = 0; p0_addr = 16'h0A00;
        p1_req = 1; p1_wr = 0; p1_addr = 16'h0B00;
        mem_rdata = 16'h2222;
        g = 0; gap = 1; prev = r_mem_req;
        for (int c = 0; c < 80 && g < 5; c++) begin
            tick();
            if (r_mem_req && !prev) begin
                chk("rr_grant", r_mem_addr, rr_exp[g]);
                chk("fp_grant", f_mem_addr, fp_exp[g]);
                chk("req_gap", (gap >= 1), 1);
                g++;
                gap = 0;
                if (g == 4) p0_req = 0;
                if (g == 5) p1_req = 0;
            end else if (!r_mem_req) begin
                gap++;
            end
            prev = r_mem_req;
        end
        chk("arb_grant_count", g, 5);
        for (int c = 0; c < 30 && r_busy; c++) tick();
        chk("arb_done_idle", r_busy, 0);
        tick();

        // Abandoned request, then spurious ack in IDLE
        p0_req = 1; p0_wr = 0; p0_addr = 16'h0C00; mem_rdata = 16'h7E57;
        tick();
        p0_req = 0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            acks += int'(r_p0_ack);
            tick();
        end
        chk("abandon_ack_count", acks, 1);
        chk("abandon_rdata", r_p0_rdata, 16'h7E57);
        spur_ack = 1;
        tick();
        spur_ack = 0;
        chk("spur_busy", r_busy, 0);
        chk("spur_mem_req", r_mem_req, 0);
        tick();
        chk("spur_acks", {r_p0_ack, r_p1_ack}, 2'b00);
        chk("spur_busy2", r_busy, 0);

        // Reset in the middle of ISSUE
        p0_req = 1; p0_wr = 1; p0_addr = 16'h1234; p0_wdata = 16'h9999;
        tick();
        chk("mid_mem_req", r_mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_mem_req", r_mem_req, 0);
        chk("mid_rst_mem_addr", r_mem_addr, 16'h0);
        chk("mid_rst_mem_wdata", r_mem_wdata, 16'h0);
        chk("mid_rst_busy", r_busy, 0);
        chk("mid_rst_p0_rdata", r_p0_rdata, 16'h0);
        p0_req = 0;
        tick(); tick();
        rst = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            acks += int'(r_p0_ack);
        end
        chk("mid_no_ack", acks, 0);
        p0_req = 1; p0_wr = 0; p0_addr = 16'h0042; mem_rdata = 16'hCAFE;
        tick();
        chk("post_rst_grant", r_mem_addr, 16'h0042);
        wait_ack(1'b0, "post_rst_ack_timeout");
        chk("post_rst_rdata", r_p0_rdata, 16'hCAFE);
        p0_req = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
